// File: rtl/ldst_queue.sv
// ldst_queue: load/store unit with an in-order store buffer, load bypass,
// optional store-to-load forwarding and big-endian byte-lane alignment.
// Byte offset k of an octa lives in bits [63-8k -: 8] and in mem_be bit k.
//
// Build option: define LDST_FORWARD_EN to build the forwarding mux and merge
// logic. When it is undefined, any load that overlaps a buffered store waits
// for those stores to drain and then reads memory.
//
// Handshakes: a transfer on a valid/ready pair happens on the rising clk edge
// where both are high. The valid side holds its payload stable until that
// edge, and never withdraws valid before it. mem_req/mem_ack follow the same
// rule, with mem_ack as the ready and mem_rdata sampled on the same edge.
module ldst_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int TAG_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_store,
  input  logic [1:0]                 req_size,
  input  logic                       req_signed,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [63:0]                req_wdata,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [63:0]                rsp_data,
  output logic                       rsp_overflow,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [7:0]                 mem_be,
  output logic [63:0]                mem_wdata,
  input  logic                       mem_ack,
  input  logic [63:0]                mem_rdata,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic [1:0]                 dbg_front_state,
  output logic                       dbg_drain_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HI_W  = ADDR_W - 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LD_WAIT = 2'd1;
  localparam logic [1:0] ST_RSP     = 2'd2;

  localparam logic [0:0] DR_IDLE = 1'b0;
  localparam logic [0:0] DR_BUSY = 1'b1;

  // Round the byte offset down to the natural alignment of the size.
  function automatic logic [2:0] align_off(input logic [2:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    align_off = a;
      2'd1:    align_off = {a[2:1], 1'b0};
      2'd2:    align_off = {a[2], 2'b00};
      default: align_off = 3'd0;
    endcase
  endfunction

  // Offset of the last byte touched; offset is aligned so OR is an add.
  function automatic logic [2:0] last_byte(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'd0:    last_byte = off;
      2'd1:    last_byte = off | 3'd1;
      2'd2:    last_byte = off | 3'd3;
      default: last_byte = 3'd7;
    endcase
  endfunction

  // Big-endian: the last byte sits at bit 8*(7-last), and 7-last == ~last.
  function automatic logic [5:0] lane_shift(input logic [2:0] last);
    lane_shift = {~last, 3'b000};
  endfunction

  function automatic logic [7:0] size_be(input logic [1:0] sz);
    case (sz)
      2'd0:    size_be = 8'h01;
      2'd1:    size_be = 8'h03;
      2'd2:    size_be = 8'h0F;
      default: size_be = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // A store value that does not fit the access size is flagged, not trapped.
  function automatic logic store_ovf(input logic [63:0] d, input logic [1:0] sz, input logic sgn);
    case (sz)
      2'd0:    store_ovf = sgn ? (d[63:8]  != {56{d[7]}})  : (d[63:8]  != '0);
      2'd1:    store_ovf = sgn ? (d[63:16] != {48{d[15]}}) : (d[63:16] != '0);
      2'd2:    store_ovf = sgn ? (d[63:32] != {32{d[31]}}) : (d[63:32] != '0);
      default: store_ovf = 1'b0;
    endcase
  endfunction

  // Pull the addressed bytes out of an octa and extend them to 64 bits.
  function automatic logic [63:0] load_extract(input logic [63:0] octa, input logic [2:0] off,
                                               input logic [1:0] sz, input logic sgn);
    logic [63:0] v;
    v = octa >> lane_shift(last_byte(off, sz));
    case (sz)
      2'd0:    load_extract = {{56{sgn & v[7]}},  v[7:0]};
      2'd1:    load_extract = {{48{sgn & v[15]}}, v[15:0]};
      2'd2:    load_extract = {{32{sgn & v[31]}}, v[31:0]};
      default: load_extract = v;
    endcase
  endfunction

  // Store buffer
  logic [DEPTH-1:0] sb_valid;
  logic [HI_W-1:0]  sb_addr [DEPTH];
  logic [7:0]       sb_be   [DEPTH];
  logic [63:0]      sb_data [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] ord_idx [DEPTH];

  // FSM state and the parked load
  logic [1:0]       front;
  logic [0:0]       dr_state;
  logic             ld_active;
  logic [HI_W-1:0]  ld_addr_hi;
  logic [7:0]       ld_be;
  logic [2:0]       ld_off;
  logic [1:0]       ld_size;
  logic             ld_signed;
  logic [TAG_W-1:0] ld_tag;

  // Decoded request
  logic [2:0]       req_off;
  logic [7:0]       req_be;
  logic [63:0]      req_lane;
  logic             req_ovf;

  // Overlap probe
  logic [HI_W-1:0]  probe_hi;
  logic [7:0]       probe_be;
  logic [7:0]       hit_be;
  logic             hit_any;
`ifdef LDST_FORWARD_EN
  logic [63:0]      fwd_data;
  logic             fwd_hit;
`endif

  // Control strobes
  logic accept, push, ld_acc, pop, full;
  logic port_free_next, ld_want, ld_start, ld_done, dr_start, dr_busy;

  // Decode size/offset into a byte mask, lane-positioned data and overflow.
  always_comb begin
    req_off  = align_off(req_addr[2:0], req_size);
    req_be   = size_be(req_size) << req_off;
    req_lane = (req_wdata & size_mask(req_size)) << lane_shift(last_byte(req_off, req_size));
    req_ovf  = store_ovf(req_wdata, req_size, req_signed);
  end

  // Probe with the incoming load while idle, else with the parked load.
  always_comb begin
    probe_hi = (front == ST_IDLE) ? req_addr[ADDR_W-1:3] : ld_addr_hi;
    probe_be = (front == ST_IDLE) ? req_be : ld_be;
  end

  // Buffer slots in age order, oldest first.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) ord_idx[k] = head + PTR_W'(k);
  end

  // Overlap scan, oldest to youngest so younger bytes overwrite older ones.
  always_comb begin
    hit_be = '0;
`ifdef LDST_FORWARD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_valid[ord_idx[k]] && (sb_addr[ord_idx[k]] == probe_hi)) begin
        hit_be = hit_be | (sb_be[ord_idx[k]] & probe_be);
`ifdef LDST_FORWARD_EN
        for (int b = 0; b < 8; b++) begin
          if (sb_be[ord_idx[k]][b]) fwd_data[63-8*b -: 8] = sb_data[ord_idx[k]][63-8*b -: 8];
        end
`endif
      end
    end
    hit_any = |hit_be;
`ifdef LDST_FORWARD_EN
    fwd_hit = (hit_be == probe_be);
`endif
  end

  // Handshake strobes and memory-port arbitration; a pending load wins.
  always_comb begin
    full           = (sb_count == CNT_W'(DEPTH));
    req_ready      = !reset && (front == ST_IDLE) && !full;
    accept         = req_valid && req_ready;
    push           = accept && req_store;
    ld_acc         = accept && !req_store;
    dr_busy        = (dr_state == DR_BUSY);
    pop            = dr_busy && mem_ack;
    ld_done        = ld_active && mem_ack;
    port_free_next = (dr_state == DR_IDLE) || pop;
    ld_want        = (ld_acc && !hit_any) ||
                     ((front == ST_LD_WAIT) && !ld_active && !hit_any);
    ld_start       = ld_want && port_free_next;
    dr_start       = (dr_state == DR_IDLE) && ((sb_count != '0) || push) &&
                     !ld_active && !ld_start;
  end

  // Memory port driven by whichever side currently owns it.
  always_comb begin
    mem_req   = ld_active || dr_busy;
    mem_we    = dr_busy;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (ld_active) begin
      mem_addr = {ld_addr_hi, 3'b000};
      mem_be   = ld_be;
    end else if (dr_busy) begin
      mem_addr  = {sb_addr[head], 3'b000};
      mem_be    = sb_be[head];
      mem_wdata = sb_data[head];
    end
  end

  assign rsp_valid       = (front == ST_RSP);
  assign dbg_front_state = front;
  assign dbg_drain_state = dr_state;

  // Front FSM: accepts requests, parks loads, holds the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      front        <= ST_IDLE;
      ld_active    <= 1'b0;
      ld_addr_hi   <= '0;
      ld_be        <= '0;
      ld_off       <= '0;
      ld_size      <= '0;
      ld_signed    <= 1'b0;
      ld_tag       <= '0;
      rsp_tag      <= '0;
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      case (front)
        ST_IDLE: begin
          if (push) begin
            rsp_tag      <= req_tag;
            rsp_data     <= '0;
            rsp_overflow <= req_ovf;
            front        <= ST_RSP;
          end else if (ld_acc) begin
            ld_addr_hi <= req_addr[ADDR_W-1:3];
            ld_be      <= req_be;
            ld_off     <= req_off;
            ld_size    <= req_size;
            ld_signed  <= req_signed;
            ld_tag     <= req_tag;
`ifdef LDST_FORWARD_EN
            if (fwd_hit) begin
              rsp_tag      <= req_tag;
              rsp_data     <= load_extract(fwd_data, req_off, req_size, req_signed);
              rsp_overflow <= 1'b0;
              front        <= ST_RSP;
            end else begin
              ld_active <= ld_start;
              front     <= ST_LD_WAIT;
            end
`else
            ld_active <= ld_start;
            front     <= ST_LD_WAIT;
`endif
          end
        end
        ST_LD_WAIT: begin
          if (ld_done) begin
            ld_active    <= 1'b0;
            rsp_tag      <= ld_tag;
            rsp_data     <= load_extract(mem_rdata, ld_off, ld_size, ld_signed);
            rsp_overflow <= 1'b0;
            front        <= ST_RSP;
          end else if (ld_start) begin
            ld_active <= 1'b1;
          end
        end
        ST_RSP: begin
          if (rsp_ready) front <= ST_IDLE;
        end
        default: front <= ST_IDLE;
      endcase
    end
  end

  // Drain engine: writes the head entry, pops it on mem_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_state <= DR_IDLE;
    end else begin
      case (dr_state)
        DR_IDLE: if (dr_start) dr_state <= DR_BUSY;
        DR_BUSY: if (mem_ack)  dr_state <= DR_IDLE;
        default: dr_state <= DR_IDLE;
      endcase
    end
  end

  // Buffer bookkeeping: valid bits, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_valid <= '0;
      head     <= '0;
      tail     <= '0;
      sb_count <= '0;
    end else begin
      if (push) begin
        sb_valid[tail] <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        sb_valid[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      sb_count <= sb_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry payload; qualified by sb_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= req_addr[ADDR_W-1:3];
      sb_be[tail]   <= req_be;
      sb_data[tail] <= req_lane;
    end
  end

endmodule
